// File: rtl/act_mem_arbiter.sv
// -----------------------------------------------------------------------------
// act_mem_arbiter
//
// Shares the single-port activation memory between the SPI bridge (external
// requester, ext_*) and the processor datapath (internal requester, int_*).
// One access is granted per cycle. In normal operation the two sides are
// served round-robin. The host can take exclusive ownership with sel_ext;
// the lock is only entered once every internal read already issued to the
// memory has come back, so the datapath never loses a read response.
//
// Handshake (both requesters): req/we/addr/wdata are held stable until gnt.
// The request retires in the cycle gnt is high; a new request may be
// presented in the very next cycle. A granted read returns exactly
// READ_LATENCY cycles later as a one-cycle rvalid pulse on the side that
// issued it, with rdata valid in that same cycle and held afterwards.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   sel_ext / ext_locked       host lock request / lock status
//   ext_req/we/addr/wdata      external request
//   ext_gnt/rvalid/rdata       external grant and read return
//   int_req/we/addr/wdata      internal request
//   int_gnt/rvalid/rdata       internal grant and read return
//   mem_en/we/addr/wdata/q     single-port memory interface
//   dbg_state                  current arbiter state (0 ARB, 1 DRAIN, 2 LOCK)
//
// Optional build macro ACT_ARB_STATS_EN adds stall counters:
//   stats_clr (in), ext_stall_cnt / int_stall_cnt (out, 16 bit, saturating).
// -----------------------------------------------------------------------------
module act_mem_arbiter #(
  parameter int WIDTH_ADDR_ACT = 12,
  parameter int WIDTH_ACT_MEM  = 8,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sel_ext,
  output logic                      ext_locked,
  input  logic                      ext_req,
  input  logic                      ext_we,
  input  logic [WIDTH_ADDR_ACT-1:0] ext_addr,
  input  logic [WIDTH_ACT_MEM-1:0]  ext_wdata,
  output logic                      ext_gnt,
  output logic                      ext_rvalid,
  output logic [WIDTH_ACT_MEM-1:0]  ext_rdata,
  input  logic                      int_req,
  input  logic                      int_we,
  input  logic [WIDTH_ADDR_ACT-1:0] int_addr,
  input  logic [WIDTH_ACT_MEM-1:0]  int_wdata,
  output logic                      int_gnt,
  output logic                      int_rvalid,
  output logic [WIDTH_ACT_MEM-1:0]  int_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [WIDTH_ADDR_ACT-1:0] mem_addr,
  output logic [WIDTH_ACT_MEM-1:0]  mem_wdata,
  input  logic [WIDTH_ACT_MEM-1:0]  mem_q,
  output logic [1:0]                dbg_state
`ifdef ACT_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [15:0]               ext_stall_cnt,
  output logic [15:0]               int_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // 1 when the most recent grant went to the internal side.
  logic last_int_q, last_int_d;

  // Read tag pipelines: bit 0 is the newest entry, bit READ_LATENCY-1 is
  // the entry whose data is on mem_q this cycle.
  logic [READ_LATENCY-1:0] tag_ext_q, tag_ext_d;
  logic [READ_LATENCY-1:0] tag_int_q, tag_int_d;

  logic [WIDTH_ACT_MEM-1:0] ext_rdata_q, ext_rdata_d;
  logic [WIDTH_ACT_MEM-1:0] int_rdata_q, int_rdata_d;

  logic int_allowed;
  logic int_inflight;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ARB;
      last_int_q  <= 1'b1;
      tag_ext_q   <= '0;
      tag_int_q   <= '0;
      ext_rdata_q <= '0;
      int_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_int_q  <= last_int_d;
      tag_ext_q   <= tag_ext_d;
      tag_int_q   <= tag_int_d;
      ext_rdata_q <= ext_rdata_d;
      int_rdata_q <= int_rdata_d;
    end
  end

  // An internal read still needs the lock to wait if it sits anywhere but
  // the last stage; the last-stage entry returns in this very cycle.
  always_comb begin
    int_inflight = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      int_inflight = int_inflight | tag_int_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB: begin
        if (sel_ext) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!sel_ext)          state_d = ST_ARB;
        else if (!int_inflight) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (!sel_ext) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: grants, memory mux, lock status
  // ---------------------------------------------------------------------------
  // The internal side is shut out as soon as sel_ext is seen, even in the
  // ARB cycle where sel_ext first rises.
  assign int_allowed = (state_q == ST_ARB) && !sel_ext;

  always_comb begin
    ext_gnt = 1'b0;
    int_gnt = 1'b0;
    if (ext_req && int_req && int_allowed) begin
      if (last_int_q) ext_gnt = 1'b1;
      else            int_gnt = 1'b1;
    end else if (ext_req) begin
      ext_gnt = 1'b1;
    end else if (int_req && int_allowed) begin
      int_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = ext_gnt | int_gnt;
    mem_we    = 1'b0;
    mem_addr  = ext_addr;
    mem_wdata = ext_wdata;
    if (int_gnt) begin
      mem_we    = int_we;
      mem_addr  = int_addr;
      mem_wdata = int_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
    end
  end

  assign ext_locked = (state_q == ST_LOCK);
  assign dbg_state  = state_q;

  always_comb begin
    last_int_d = last_int_q;
    if (ext_gnt)      last_int_d = 1'b0;
    else if (int_gnt) last_int_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_ext_d    = '0;
    tag_int_d    = '0;
    tag_ext_d[0] = ext_gnt & ~ext_we;
    tag_int_d[0] = int_gnt & ~int_we;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_ext_d[i] = tag_ext_q[i-1];
      tag_int_d[i] = tag_int_q[i-1];
    end
  end

  assign ext_rvalid = tag_ext_q[READ_LATENCY-1];
  assign int_rvalid = tag_int_q[READ_LATENCY-1];

  // mem_q is forwarded during the rvalid cycle and captured so the value
  // stays on rdata until that side's next read returns.
  assign ext_rdata_d = ext_rvalid ? mem_q : ext_rdata_q;
  assign int_rdata_d = int_rvalid ? mem_q : int_rdata_q;
  assign ext_rdata   = ext_rdata_d;
  assign int_rdata   = int_rdata_d;

`ifdef ACT_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics
  // ---------------------------------------------------------------------------
  logic [15:0] ext_stall_q, ext_stall_d;
  logic [15:0] int_stall_q, int_stall_d;

  always_comb begin
    ext_stall_d = ext_stall_q;
    int_stall_d = int_stall_q;
    if (stats_clr) begin
      ext_stall_d = '0;
      int_stall_d = '0;
    end else begin
      if (ext_req && !ext_gnt && ext_stall_q != 16'hFFFF) ext_stall_d = ext_stall_q + 16'd1;
      if (int_req && !int_gnt && int_stall_q != 16'hFFFF) int_stall_d = int_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_stall_q <= '0;
      int_stall_q <= '0;
    end else begin
      ext_stall_q <= ext_stall_d;
      int_stall_q <= int_stall_d;
    end
  end

  assign ext_stall_cnt = ext_stall_q;
  assign int_stall_cnt = int_stall_q;
`endif

endmodule

// File: tb/tb_act_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_act_mem_arbiter
//
// Drives act_mem_arbiter (READ_LATENCY = 2) against a behavioural memory.
// Phase 1: cycle-by-cycle vector table from reset (write/read-back, round
//          robin, lock entry with drain, lock exit, drain abort).
// Phase 2: hand-written asynchronous-reset sequence.
// Phase 3: random traffic checked against a transaction-level model
//          (round-robin rule, model memory, per-side expected read queues).
// Phase 4: stall counters when built with ACT_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_act_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          sel_ext;
  logic          ext_locked;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          int_req, int_we;
  logic [AW-1:0] int_addr;
  logic [DW-1:0] int_wdata;
  logic          int_gnt, int_rvalid;
  logic [DW-1:0] int_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
  logic [1:0]    dbg_state;
`ifdef ACT_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   ext_stall_cnt, int_stall_cnt;
`endif

  always #5 clk = ~clk;

  act_mem_arbiter #(
    .WIDTH_ADDR_ACT(AW),
    .WIDTH_ACT_MEM (DW),
    .READ_LATENCY  (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_ext    (sel_ext),
    .ext_locked (ext_locked),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .int_req    (int_req),
    .int_we     (int_we),
    .int_addr   (int_addr),
    .int_wdata  (int_wdata),
    .int_gnt    (int_gnt),
    .int_rvalid (int_rvalid),
    .int_rdata  (int_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_q      (mem_q),
    .dbg_state  (dbg_state)
`ifdef ACT_ARB_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .ext_stall_cnt (ext_stall_cnt),
    .int_stall_cnt (int_stall_cnt)
`endif
  );

  // Behavioural single-port memory with RL-cycle read latency.
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem_arr[mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[RL-1];

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sel_ext = 1'b0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    int_req = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          sel;
    logic          er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic          eg, ig, erv, irv;
    logic [DW-1:0] erd, ird;
    logic          lk;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic sel,
    input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
    input logic ir, input logic iw, input logic [AW-1:0] ia, input logic [DW-1:0] id,
    input logic eg, input logic ig, input logic erv, input logic irv,
    input logic [DW-1:0] erd, input logic [DW-1:0] ird, input logic lk);
    vec_t v;
    v.sel = sel; v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
    v.ir = ir; v.iw = iw; v.ia = ia; v.id = id;
    v.eg = eg; v.ig = ig; v.erv = erv; v.irv = irv;
    v.erd = erd; v.ird = ird; v.lk = lk;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Random-phase model state
  // ---------------------------------------------------------------------------
  logic          pe_v, pe_we;
  logic [AW-1:0] pe_a;
  logic [DW-1:0] pe_d;
  logic          pi_v, pi_we;
  logic [AW-1:0] pi_a;
  logic [DW-1:0] pi_d;
  logic          mdl_last_int;
  logic [DW-1:0] mdl_mem [16];
  logic [DW-1:0] ext_exp_q [$];
  logic [DW-1:0] int_exp_q [$];
  int            ext_due_q [$];
  int            int_due_q [$];
  int            cyc;

  task automatic rnd_cycle(input bit gen);
    logic eg, ig, erv, irv;
    if (gen) begin
      if (!pe_v && $urandom_range(0, 9) < 6) begin
        pe_v = 1'b1; pe_we = 1'($urandom_range(0, 1));
        pe_a = AW'($urandom_range(0, 15)); pe_d = DW'($urandom_range(0, 255));
      end
      if (!pi_v && $urandom_range(0, 9) < 6) begin
        pi_v = 1'b1; pi_we = 1'($urandom_range(0, 1));
        pi_a = AW'($urandom_range(0, 15)); pi_d = DW'($urandom_range(0, 255));
      end
    end
    ext_req = pe_v; ext_we = pe_we; ext_addr = pe_a; ext_wdata = pe_d;
    int_req = pi_v; int_we = pi_we; int_addr = pi_a; int_wdata = pi_d;
    #1;
    // Round-robin rule: contention goes to the side not served last.
    eg = pe_v && (!pi_v || mdl_last_int);
    ig = pi_v && (!pe_v || !mdl_last_int);
    chk($sformatf("rnd%0d ext_gnt", cyc), ext_gnt, eg);
    chk($sformatf("rnd%0d int_gnt", cyc), int_gnt, ig);
    chk($sformatf("rnd%0d mem_en", cyc), mem_en, eg | ig);
    if (eg) begin
      chk($sformatf("rnd%0d mem_we", cyc), mem_we, pe_we);
      chk($sformatf("rnd%0d mem_addr", cyc), mem_addr, pe_a);
      if (pe_we) chk($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, pe_d);
    end else if (ig) begin
      chk($sformatf("rnd%0d mem_we", cyc), mem_we, pi_we);
      chk($sformatf("rnd%0d mem_addr", cyc), mem_addr, pi_a);
      if (pi_we) chk($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, pi_d);
    end else begin
      chk($sformatf("rnd%0d mem_we idle", cyc), mem_we, 1'b0);
      chk($sformatf("rnd%0d mem_addr idle", cyc), mem_addr, ext_addr);
    end
    erv = (ext_due_q.size() > 0) && (ext_due_q[0] == cyc);
    irv = (int_due_q.size() > 0) && (int_due_q[0] == cyc);
    chk($sformatf("rnd%0d ext_rvalid", cyc), ext_rvalid, erv);
    chk($sformatf("rnd%0d int_rvalid", cyc), int_rvalid, irv);
    if (erv) begin
      chk($sformatf("rnd%0d ext_rdata", cyc), ext_rdata, ext_exp_q[0]);
      void'(ext_exp_q.pop_front()); void'(ext_due_q.pop_front());
    end
    if (irv) begin
      chk($sformatf("rnd%0d int_rdata", cyc), int_rdata, int_exp_q[0]);
      void'(int_exp_q.pop_front()); void'(int_due_q.pop_front());
    end
    if (eg) begin
      mdl_last_int = 1'b0;
      if (pe_we) mdl_mem[pe_a[3:0]] = pe_d;
      else begin ext_exp_q.push_back(mdl_mem[pe_a[3:0]]); ext_due_q.push_back(cyc + RL); end
      pe_v = 1'b0;
    end
    if (ig) begin
      mdl_last_int = 1'b1;
      if (pi_we) mdl_mem[pi_a[3:0]] = pi_d;
      else begin int_exp_q.push_back(mdl_mem[pi_a[3:0]]); int_due_q.push_back(cyc + RL); end
      pi_v = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Time limit: far above the few hundred cycles the sequence needs.
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
`ifdef ACT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    //           sel er ew ea      ed     ir iw ia      id     eg ig erv irv erd    ird    lk
    tbl[0]  = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0,  1, 1, 12'h005, 8'hA5, 0, 0, 12'h000, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0,  1, 0, 12'h005, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[3]  = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[4]  = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h00, 0);
    tbl[5]  = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00, 0);
    tbl[6]  = mk(0,  1, 1, 12'h010, 8'h11, 0, 0, 12'h000, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00, 0);
    tbl[7]  = mk(0,  0, 0, 12'h000, 8'h00, 1, 1, 12'h011, 8'h22, 0, 1, 0, 0, 8'hA5, 8'h00, 0);
    tbl[8]  = mk(0,  1, 0, 12'h010, 8'h00, 1, 0, 12'h011, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00, 0);
    tbl[9]  = mk(0,  1, 0, 12'h005, 8'h00, 1, 0, 12'h011, 8'h00, 0, 1, 0, 0, 8'hA5, 8'h00, 0);
    tbl[10] = mk(0,  1, 0, 12'h005, 8'h00, 1, 0, 12'h010, 8'h00, 1, 0, 1, 0, 8'h11, 8'h00, 0);
    tbl[11] = mk(0,  1, 0, 12'h011, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 0, 1, 8'h11, 8'h22, 0);
    tbl[12] = mk(0,  1, 0, 12'h011, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 1, 0, 8'hA5, 8'h22, 0);
    tbl[13] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h11, 0);
    tbl[14] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 8'h22, 8'h11, 0);
    tbl[15] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h22, 8'h11, 0);
    // Int read at 16, sel_ext at 17: int_rvalid at 18, locked from 19.
    tbl[16] = mk(0,  0, 0, 12'h000, 8'h00, 1, 0, 12'h005, 8'h00, 0, 1, 0, 0, 8'h22, 8'h11, 0);
    tbl[17] = mk(1,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 0, 0, 0, 8'h22, 8'h11, 0);
    tbl[18] = mk(1,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 0, 0, 1, 8'h22, 8'hA5, 0);
    tbl[19] = mk(1,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 0, 0, 0, 8'h22, 8'hA5, 1);
    tbl[20] = mk(1,  1, 1, 12'h020, 8'h33, 1, 0, 12'h010, 8'h00, 1, 0, 0, 0, 8'h22, 8'hA5, 1);
    tbl[21] = mk(1,  1, 0, 12'h020, 8'h00, 1, 0, 12'h010, 8'h00, 1, 0, 0, 0, 8'h22, 8'hA5, 1);
    tbl[22] = mk(1,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 0, 0, 0, 8'h22, 8'hA5, 1);
    // sel_ext dropped at 23: held int request granted at 24.
    tbl[23] = mk(0,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 0, 1, 0, 8'h33, 8'hA5, 1);
    tbl[24] = mk(0,  0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 0, 0, 8'h33, 8'hA5, 0);
    tbl[25] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h33, 8'hA5, 0);
    tbl[26] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 8'h33, 8'h11, 0);
    // Drain abandoned: sel_ext pulse for one ARB and one DRAIN cycle.
    tbl[27] = mk(0,  0, 0, 12'h000, 8'h00, 1, 0, 12'h005, 8'h00, 0, 1, 0, 0, 8'h33, 8'h11, 0);
    tbl[28] = mk(1,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h33, 8'h11, 0);
    tbl[29] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 8'h33, 8'hA5, 0);
    tbl[30] = mk(0,  0, 0, 12'h000, 8'h00, 1, 0, 12'h011, 8'h00, 0, 1, 0, 0, 8'h33, 8'hA5, 0);
    tbl[31] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h33, 8'hA5, 0);
    tbl[32] = mk(0,  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 8'h33, 8'h22, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ---- Phase 1: vector table ----
    for (int r = 0; r < NV; r++) begin
      sel_ext = tbl[r].sel;
      ext_req = tbl[r].er; ext_we = tbl[r].ew; ext_addr = tbl[r].ea; ext_wdata = tbl[r].ed;
      int_req = tbl[r].ir; int_we = tbl[r].iw; int_addr = tbl[r].ia; int_wdata = tbl[r].id;
      #1;
      chk($sformatf("v%0d ext_gnt", r), ext_gnt, tbl[r].eg);
      chk($sformatf("v%0d int_gnt", r), int_gnt, tbl[r].ig);
      chk($sformatf("v%0d mem_en", r), mem_en, tbl[r].eg | tbl[r].ig);
      chk($sformatf("v%0d ext_rvalid", r), ext_rvalid, tbl[r].erv);
      chk($sformatf("v%0d int_rvalid", r), int_rvalid, tbl[r].irv);
      chk($sformatf("v%0d ext_rdata", r), ext_rdata, tbl[r].erd);
      chk($sformatf("v%0d int_rdata", r), int_rdata, tbl[r].ird);
      chk($sformatf("v%0d ext_locked", r), ext_locked, tbl[r].lk);
      if (tbl[r].eg) begin
        chk($sformatf("v%0d mem_we", r), mem_we, tbl[r].ew);
        chk($sformatf("v%0d mem_addr", r), mem_addr, tbl[r].ea);
      end
      if (tbl[r].ig) begin
        chk($sformatf("v%0d mem_we", r), mem_we, tbl[r].iw);
        chk($sformatf("v%0d mem_addr", r), mem_addr, tbl[r].ia);
      end
      @(negedge clk);
    end

    // ---- Phase 2: reset one cycle after an int read grant ----
    idle_inputs();
    int_req = 1'b1; int_addr = 12'h005;
    #1 chk("rst int read gnt", int_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h0FF; ext_wdata = 8'h5A;
    #1 chk("rst ext write gnt", ext_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("in rst int_rvalid", int_rvalid, 1'b0);
    chk("in rst ext_locked", ext_locked, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      #1;
      chk($sformatf("post rst%0d int_rvalid", k), int_rvalid, 1'b0);
      chk($sformatf("post rst%0d ext_rvalid", k), ext_rvalid, 1'b0);
      chk($sformatf("post rst%0d int_rdata", k), int_rdata, 8'h00);
      chk($sformatf("post rst%0d ext_rdata", k), ext_rdata, 8'h00);
      chk($sformatf("post rst%0d gnt", k), {ext_gnt, int_gnt}, 2'b00);
      chk($sformatf("post rst%0d ext_locked", k), ext_locked, 1'b0);
      @(negedge clk);
    end
    // After reset the external side wins the first contention.
    ext_req = 1'b1; ext_addr = 12'h005;
    int_req = 1'b1; int_addr = 12'h011;
    #1 chk("post rst contention ext_gnt", ext_gnt, 1'b1);
    chk("post rst contention int_gnt", int_gnt, 1'b0);
    @(negedge clk);
    ext_req = 1'b0;
    #1 chk("post rst int follows", int_gnt, 1'b1);
    @(negedge clk);
    int_req = 1'b0;
    #1 chk("post rst ext_rvalid", ext_rvalid, 1'b1);
    chk("post rst ext_rdata", ext_rdata, 8'hA5);
    @(negedge clk);
    #1 chk("post rst int_rvalid", int_rvalid, 1'b1);
    chk("post rst int_rdata", int_rdata, 8'h22);
    @(negedge clk);
    @(negedge clk);

    // ---- Phase 3: random traffic (sel_ext low) ----
    idle_inputs();
    cyc = 0;
    mdl_last_int = 1'b1;
    pe_v = 1'b0; pe_we = 1'b0; pe_a = '0; pe_d = '0;
    pi_v = 1'b0; pi_we = 1'b0; pi_a = '0; pi_d = '0;
    for (int a = 0; a < 16; a++) begin
      pe_v = 1'b1; pe_we = 1'b1; pe_a = AW'(a); pe_d = DW'($urandom_range(0, 255));
      rnd_cycle(1'b0);
    end
    for (int n = 0; n < 400; n++) rnd_cycle(1'b1);
    pe_v = 1'b0; pi_v = 1'b0;
    for (int n = 0; n < RL + 2; n++) rnd_cycle(1'b0);
    chk("rnd ext reads outstanding", ext_due_q.size(), 0);
    chk("rnd int reads outstanding", int_due_q.size(), 0);
    idle_inputs();

`ifdef ACT_ARB_STATS_EN
    // ---- Phase 4: stall counters ----
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    sel_ext = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("stats ext_locked", ext_locked, 1'b1);
    int_req = 1'b1; int_addr = 12'h003;
    repeat (3) @(negedge clk);
    int_req = 1'b0;
    #1 chk("stats int_stall_cnt", int_stall_cnt, 16'd3);
    chk("stats ext_stall_cnt", ext_stall_cnt, 16'd0);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1 chk("stats int_stall_cnt clr", int_stall_cnt, 16'd0);
    sel_ext = 1'b0;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/act_mem_arbiter.md
Name: act_mem_arbiter

Overview:
- Shares the single-port activation memory between two requesters, one access per cycle.
- The external requester is the SPI bridge (host load/readback). The internal requester is the processor datapath (layer activation reads/writes).
- Round-robin arbitration in normal mode. A host-driven exclusive lock (sel_ext) gives the SPI side sole ownership, but only after in-flight reads drain.
- Returns read data to the requester that issued the read, with a fixed memory latency.

Parameters:
WIDTH_ADDR_ACT, 12, activation memory address width
WIDTH_ACT_MEM, 8, activation memory data width
READ_LATENCY, 1, cycles from mem_en (read) to valid mem_q; legal 1..3

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
sel_ext  input  1  host request for exclusive external ownership
ext_locked  output  1  high while in EXT_LOCK state
ext_req  input  1  external access request, held until ext_gnt
ext_we  input  1  external write (1) / read (0)
ext_addr  input  WIDTH_ADDR_ACT  external address
ext_wdata  input  WIDTH_ACT_MEM  external write data
ext_gnt  output  1  external access accepted this cycle
ext_rvalid  output  1  external read data valid
ext_rdata  output  WIDTH_ACT_MEM  external read data
int_req, int_we, int_addr, int_wdata  input  1/1/WIDTH_ADDR_ACT/WIDTH_ACT_MEM  internal request (same rules as ext_*)
int_gnt, int_rvalid  output  1  internal grant / read valid
int_rdata  output  WIDTH_ACT_MEM  internal read data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  WIDTH_ADDR_ACT  memory address
mem_wdata  output  WIDTH_ACT_MEM  memory write data
mem_q  input  WIDTH_ACT_MEM  memory read data

Behaviour:
- Reset values: all gnt/rvalid = 0; ext_locked = 0; state = ARB; last_grant = INT (so ext wins the first contention); read tag pipeline cleared. rdata outputs are 0 at reset.
- Grant logic:
  - Grants are combinational from state, req and last_grant; at most one grant per cycle.
  - mem_en = ext_gnt | int_gnt. mem_we/mem_addr/mem_wdata are muxed from the granted requester in the same cycle.
  - When no grant, mem_we = 0 and mem_addr/mem_wdata hold the external inputs.
- Requester rule: req, we, addr and wdata stay stable until gnt; the request retires in the gnt cycle. Back-to-back grants to one requester are allowed.
- ARB state:
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - last_grant updates on every grant.
- Read return:
  - Each granted read pushes a tag (ext/int) into a READ_LATENCY-deep shift pipeline. Writes push an empty slot.
  - When a tag exits the pipeline, the matching rvalid pulses for 1 cycle and its rdata is registered from mem_q.
  - The other requester's rdata holds its previous value.
- State machine:
  - ARB → DRAIN_TO_EXT when sel_ext = 1. No int grants from that cycle on; ext grants are still allowed.
  - DRAIN_TO_EXT → EXT_LOCK when no int-tagged read is in flight. Ext-tagged reads may remain in flight.
  - EXT_LOCK: only ext granted; ext_locked = 1.
  - EXT_LOCK → ARB when sel_ext = 0. There is no drain on exit because int has nothing outstanding.
  - DRAIN_TO_EXT → ARB directly if sel_ext drops before the drain completes.
- Boundary conditions:
  - sel_ext rising in the same cycle as an int request: int is not granted.
  - A read issued in the last cycle before a state change still returns its rvalid normally.
  - int_req held during EXT_LOCK stays pending and is granted on the first ARB cycle.
  - Asynchronous reset mid-transaction discards in-flight tags; no rvalid is generated after reset release for pre-reset reads.

Optional Feature:
Macro ACT_ARB_STATS_EN.
- Defined:
  - Adds outputs ext_stall_cnt and int_stall_cnt (16 bits each).
  - Each counter increments every cycle its req = 1 and gnt = 0, and saturates at 16'hFFFF.
  - Both counters are cleared by reset or by a stats_clr input pulse (1 bit, added with the feature).
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then ext write addr 0x005 data 0xA5 followed by ext read of 0x005 → ext_gnt on both requests; ext_rvalid = 1 exactly READ_LATENCY cycles after the read grant with ext_rdata = 0xA5; int_rvalid stays 0.
- ext_req and int_req both held for 4 cycles with distinct reads → grants alternate ext, int, ext, int; each rvalid is routed to the issuing side.
- Int read granted at cycle t, sel_ext asserted at t+1, READ_LATENCY = 2 → int_rvalid at t+2; ext_locked = 1 at t+3; int_req held throughout gets no grant while locked.
- In EXT_LOCK, int_req held, sel_ext dropped at cycle t → int_gnt at t+1 when ext_req = 0; ext_locked = 0 at t+1.
- Reset pulsed one cycle after an int read grant (READ_LATENCY = 2) → no int_rvalid after release; all outputs return to their reset values.
- ACT_ARB_STATS_EN: int_req held 3 cycles while EXT_LOCK → int_stall_cnt = 3; a stats_clr pulse → 0.
